spi_flash_master: RTL and testbench

SPI_FLASH_MASTER -- requirements
Module: spi_flash_master

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clkgen.sv | 42 ++++
 rtl/spi_flash_master.sv | 107 ++++++++++
 tb/tb_spi_flash_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode constants and master state encoding
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    // Mode 0: sck idles low, data sampled on the rising sck transition.
    localparam logic       SPI_CPOL      = 1'b0;
    localparam int         SPI_BITS      = 8;
    localparam logic [3:0] SPI_LAST_HALF = 4'(2 * SPI_BITS - 1);

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCK half-period divider with rise/fall strobes
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic resetq,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int             CW      = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0]  HC_LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] hcnt;
    logic          half_end;

    assign half_end = en && (hcnt == HC_LAST);
    // Strobes mark the edge on which sck is about to change, so the master
    // acts on the same edge the pin moves.
    assign rise     = half_end && (sck == SPI_CPOL);
    assign fall     = half_end && (sck != SPI_CPOL);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            hcnt <= '0;
            sck  <= SPI_CPOL;
        end else if (!en) begin
            hcnt <= '0;
            sck  <= SPI_CPOL;
        end else if (half_end) begin
            hcnt <= '0;
            sck  <= ~sck;
        end else begin
            hcnt <= hcnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_master.sv
// rtl/spi_flash_master.sv - mode-0 SPI byte master for a serial flash port
module spi_flash_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic                wr,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                cs_wr,
    input  logic                cs_level,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                busy,
    output logic                done,
    output logic                sck,
    output logic                mosi,
    input  logic                miso,
    output logic                cs_n
);

    spi_state_t          state_q;
    spi_state_t          state_d;
    logic [SPI_BITS-1:0] tx_sh;
    logic [SPI_BITS-1:0] rx_sh;
    logic [SPI_BITS-1:0] rx_data_q;
    logic [3:0]          bcnt;
    logic                done_q;
    logic                cs_n_q;
    logic                rise;
    logic                fall;
    logic                last_fall;

    spi_clkgen #(
        .HALF_DIV (HALF_DIV)
    ) u_clkgen (
        .clk    (clk),
        .resetq (resetq),
        .en     (state_q == ST_SHIFT),
        .sck    (sck),
        .rise   (rise),
        .fall   (fall)
    );

    assign last_fall = fall && (bcnt == SPI_LAST_HALF);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr)        state_d = ST_SHIFT;
            ST_SHIFT: if (last_fall) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data_q <= '0;
            bcnt      <= '0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (cs_wr) begin
                    cs_n_q <= cs_level;
                end
                if (wr) begin
                    tx_sh <= tx_data;
                    bcnt  <= '0;
                end
            end else begin
                if (rise || fall) begin
                    bcnt <= bcnt + 4'd1;
                end
                if (rise) begin
                    rx_sh <= {rx_sh[SPI_BITS-2:0], miso};
                end
                // The final falling transition ends the byte instead of
                // advancing mosi, so the last bit stays on the pin.
                if (last_fall) begin
                    rx_data_q <= rx_sh;
                    done_q    <= 1'b1;
                end else if (fall) begin
                    tx_sh <= {tx_sh[SPI_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign mosi    = tx_sh[SPI_BITS-1];
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign cs_n    = cs_n_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// tb/tb_spi_flash_master.sv - self-checking bench for spi_flash_master
module tb_spi_flash_master;

    localparam int M_RND  = 0;
    localparam int M_LOOP = 1;
    localparam int M_ONE  = 2;

    typedef struct {
        logic       sel;
        logic [7:0] tx;
        int         mode;
        logic [7:0] rx;
    } vec_t;

    logic       clk;
    logic       resetq;
    logic       wr;
    logic [7:0] tx_data;
    logic       cs_wr;
    logic       cs_level;
    logic       cur;
    logic       rnd_bit;
    int         cur_mode;

    logic       wr1, wr2, cs_wr1, cs_wr2, miso1, miso2;
    logic [7:0] rx1, rx2;
    logic       busy1, busy2, done1, done2, sck1, sck2, mosi1, mosi2, cs_n1, cs_n2;

    logic [7:0] m_rx;
    logic       m_busy, m_done, m_sck, m_mosi, m_cs_n;

    int   vectors;
    int   miscompares;
    logic exp_cs [2];

    int   opt_ign, opt_cs, opt_abort, opt_next, opt_cs_start;
    bit   opt_chained;

    vec_t       tbl [6];
    logic [7:0] rx_m;

    assign wr2    = wr & ~cur;
    assign wr1    = wr & cur;
    assign cs_wr2 = cs_wr & ~cur;
    assign cs_wr1 = cs_wr & cur;
    assign miso2  = (cur_mode == M_LOOP) ? mosi2 : rnd_bit;
    assign miso1  = (cur_mode == M_LOOP) ? mosi1 : rnd_bit;

    assign m_rx   = cur ? rx1   : rx2;
    assign m_busy = cur ? busy1 : busy2;
    assign m_done = cur ? done1 : done2;
    assign m_sck  = cur ? sck1  : sck2;
    assign m_mosi = cur ? mosi1 : mosi2;
    assign m_cs_n = cur ? cs_n1 : cs_n2;

    spi_flash_master #(.HALF_DIV(2)) dut2 (
        .clk(clk), .resetq(resetq), .wr(wr2), .tx_data(tx_data),
        .cs_wr(cs_wr2), .cs_level(cs_level), .rx_data(rx2), .busy(busy2),
        .done(done2), .sck(sck2), .mosi(mosi2), .miso(miso2), .cs_n(cs_n2)
    );

    spi_flash_master #(.HALF_DIV(1)) dut1 (
        .clk(clk), .resetq(resetq), .wr(wr1), .tx_data(tx_data),
        .cs_wr(cs_wr1), .cs_level(cs_level), .rx_data(rx1), .busy(busy1),
        .done(done1), .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (div=%0d): got %0h expected %0h at %0t", name, cur ? 1 : 2, act, exp, $time);
        end
    endtask

    task automatic clear_opts();
        opt_ign      = -1;
        opt_cs       = -1;
        opt_abort    = -1;
        opt_next     = -1;
        opt_cs_start = -1;
        opt_chained  = 1'b0;
    endtask

    task automatic cs_set(input logic lvl);
        @(negedge clk);
        cs_wr    = 1'b1;
        cs_level = lvl;
        @(negedge clk);
        cs_wr = 1'b0;
        exp_cs[cur] = lvl;
        chk("cs_set", m_cs_n, lvl);
    endtask

    // Reference timing: cycle t after the load edge sits in half-period t/h;
    // sck is high in odd half-periods, bit t/(2h) is on mosi, and the rising
    // transition samples miso as it was during cycle (2i+1)h-1.
    task automatic xfer(input logic [7:0] tx, input int mode, output logic [7:0] rx_exp);
        int   h;
        int   rises;
        int   busy_n;
        logic prev_sck;
        logic mbit;
        h        = cur ? 1 : 2;
        rises    = 0;
        busy_n   = 0;
        prev_sck = 1'b0;
        rx_exp   = 8'h00;
        cur_mode = mode;
        if (!opt_chained) begin
            @(negedge clk);
            chk("idle_busy", m_busy, 0);
            wr      = 1'b1;
            tx_data = tx;
            if (opt_cs_start >= 0) begin
                cs_wr       = 1'b1;
                cs_level    = opt_cs_start[0];
                exp_cs[cur] = opt_cs_start[0];
            end
        end
        @(negedge clk);
        cs_wr = 1'b0;
        for (int t = 0; t < 16 * h; t++) begin
            if (m_busy) busy_n++;
            if (m_sck && !prev_sck) rises++;
            prev_sck = m_sck;
            chk("sck", m_sck, ((t / h) % 2) == 1);
            chk("mosi", m_mosi, tx[7 - t / (2 * h)]);
            chk("cs_n", m_cs_n, exp_cs[cur]);
            chk("done_mid", m_done, 0);
            mbit = (mode == M_LOOP) ? tx[7 - t / (2 * h)] :
                   (mode == M_ONE)  ? 1'b1 : 1'($urandom % 2);
            rnd_bit = mbit;
            if ((t % (2 * h)) == h - 1) rx_exp[7 - t / (2 * h)] = mbit;
            wr      = (t == opt_ign);
            tx_data = (t == opt_ign) ? 8'h00 : tx_data;
            cs_wr   = (t == opt_cs);
            if (t == opt_cs) cs_level = ~exp_cs[cur];
            if (t == opt_abort) begin
                wr     = 1'b0;
                resetq = 1'b0;
                #1;
                chk("abort_sck", m_sck, 0);
                chk("abort_cs_n", m_cs_n, 1);
                chk("abort_busy", m_busy, 0);
                chk("abort_done", m_done, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", m_done, 0);
                end
                resetq    = 1'b1;
                exp_cs[0] = 1'b1;
                exp_cs[1] = 1'b1;
                return;
            end
            @(negedge clk);
        end
        wr    = 1'b0;
        cs_wr = 1'b0;
        chk("busy_cycles", busy_n, 16 * h);
        chk("sck_rises", rises, 8);
        chk("busy_end", m_busy, 0);
        chk("done", m_done, 1);
        chk("sck_end", m_sck, 0);
        chk("rx_data", m_rx, rx_exp);
        if (opt_next >= 0) begin
            wr      = 1'b1;
            tx_data = opt_next[7:0];
        end else begin
            @(negedge clk);
            chk("done_once", m_done, 0);
            chk("busy_after", m_busy, 0);
            chk("rx_hold", m_rx, rx_exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetq      = 1'b0;
        wr          = 1'b0;
        cs_wr       = 1'b0;
        cs_level    = 1'b1;
        tx_data     = 8'h00;
        cur         = 1'b0;
        rnd_bit     = 1'b0;
        cur_mode    = M_RND;
        exp_cs[0]   = 1'b1;
        exp_cs[1]   = 1'b1;
        clear_opts();

        tbl[0] = '{1'b0, 8'hA5, M_LOOP, 8'hA5};
        tbl[1] = '{1'b1, 8'h00, M_ONE,  8'hFF};
        tbl[2] = '{1'b0, 8'h3C, M_LOOP, 8'h3C};
        tbl[3] = '{1'b1, 8'hC3, M_LOOP, 8'hC3};
        tbl[4] = '{1'b0, 8'h00, M_ONE,  8'hFF};
        tbl[5] = '{1'b1, 8'h81, M_LOOP, 8'h81};

        #12;
        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            chk("rst_busy", m_busy, 0);
            chk("rst_done", m_done, 0);
            chk("rst_sck", m_sck, 0);
            chk("rst_mosi", m_mosi, 0);
            chk("rst_cs_n", m_cs_n, 1);
            chk("rst_rx", m_rx, 0);
        end
        cur = 1'b0;
        @(negedge clk);
        resetq = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cur = tbl[i].sel;
            if (exp_cs[cur] != 1'b0) cs_set(1'b0);
            xfer(tbl[i].tx, tbl[i].mode, rx_m);
            chk("rx_table", m_rx, tbl[i].rx);
        end

        cur = 1'b0;
        opt_ign = 5;
        xfer(8'h9F, M_LOOP, rx_m);
        chk("ign_rx", m_rx, 8'h9F);
        clear_opts();

        opt_next = 8'h5A;
        xfer(8'hC6, M_RND, rx_m);
        clear_opts();
        opt_chained = 1'b1;
        xfer(8'h5A, M_LOOP, rx_m);
        chk("b2b_rx", m_rx, 8'h5A);
        clear_opts();

        opt_cs = 3;
        xfer(8'hE7, M_RND, rx_m);
        clear_opts();
        chk("cs_held", m_cs_n, 0);
        cs_set(1'b1);

        opt_cs_start = 0;
        xfer(8'h18, M_LOOP, rx_m);
        clear_opts();

        opt_abort = 10;
        xfer(8'hF0, M_LOOP, rx_m);
        clear_opts();
        chk("abort_rx_cleared", m_rx, 0);
        chk("abort_busy_after", m_busy, 0);
        cs_set(1'b0);
        xfer(8'h3C, M_LOOP, rx_m);
        chk("post_reset_rx", m_rx, 8'h3C);

        for (int n = 0; n < 24; n++) begin
            cur = 1'($urandom % 2);
            if (exp_cs[cur] != 1'b0) cs_set(1'b0);
            repeat ($urandom % 3) @(negedge clk);
            xfer(8'($urandom), int'($urandom % 3), rx_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
